// File: rtl/video_sprite_pixel_gen_if.sv
// Register write bus from the TinyQV peripheral wrapper into the sprite pixel generator.
// Latency: none (wires only); a write takes effect on the clock edge where wr_en is high.
// Backpressure: none; every strobed write is accepted, one write per cycle.
// Signals: wr_en (1-cycle write strobe), wr_addr[2:0] (register select), wr_data[31:0] (write data).
interface video_sprite_pixel_gen_if;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/video_sprite_pixel_gen.sv
// Background colour plus one 16x16 monochrome sprite, shadow registers committed at start of vblank.
// Latency: 2 cycles from hpos/vpos/syncs/display_on to rgb_out/hsync_out/vsync_out.
// Backpressure: none; the pixel stream is free-running and register writes are always accepted.
// Ports: clk, rst (sync, active-high); hpos/vpos/hsync_in/vsync_in/display_on_in from the timing
// generator; wr (register write bus, slave side); rgb_out {R1,R0,G1,G0,B1,B0}, hsync_out, vsync_out,
// irq (sticky vblank level), frame_count (commits since reset).
module video_sprite_pixel_gen #(
    parameter int COORD_W  = 10,
    parameter int V_ACTIVE = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COORD_W-1:0]      hpos,
    input  logic [COORD_W-1:0]      vpos,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    display_on_in,
    video_sprite_pixel_gen_if.slave wr,
    output logic [5:0]              rgb_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    irq,
    output logic [15:0]             frame_count
);

    // Pending (CPU-visible) and active (drawn) register copies
    logic [5:0]         bg_pend_q, bg_pend_d, fg_pend_q, fg_pend_d;
    logic [COORD_W-1:0] x_pend_q, x_pend_d, y_pend_q, y_pend_d;
    logic               en_pend_q, en_pend_d;
    logic [5:0]         bg_act_q, fg_act_q;
    logic [COORD_W-1:0] x_act_q, y_act_q;
    logic               en_act_q;
    logic [15:0]        bitmap_q [16];

    logic               irq_q, irq_d;
    logic [15:0]        frame_q;

    // Pipeline stage 1 / stage 2
    logic               hit_q, hit_d, disp_q, hs1_q, vs1_q;
    logic [3:0]         col_q, col_d, row_q, row_d;
    logic [5:0]         rgb_q, rgb_d;
    logic               hs2_q, vs2_q;

    logic               commit;
    logic               irq_clr;
    logic [COORD_W:0]   hx, vy, x_lo, x_hi, y_lo, y_hi;
    logic [15:0]        row_bits;
    logic               wr_unused;

    assign wr_unused = &{1'b0, wr.wr_data[31:20]};

    assign commit  = (hpos == '0) && (vpos == COORD_W'(V_ACTIVE));
    assign irq_clr = wr.wr_en && (wr.wr_addr == 3'd5) && wr.wr_data[1];

    always_comb begin
        bg_pend_d = bg_pend_q;
        fg_pend_d = fg_pend_q;
        x_pend_d  = x_pend_q;
        y_pend_d  = y_pend_q;
        en_pend_d = en_pend_q;
        if (wr.wr_en) begin
            case (wr.wr_addr)
                3'd0:    bg_pend_d = wr.wr_data[5:0];
                3'd1:    fg_pend_d = wr.wr_data[5:0];
                3'd2:    x_pend_d  = wr.wr_data[COORD_W-1:0];
                3'd3:    y_pend_d  = wr.wr_data[COORD_W-1:0];
                3'd5:    en_pend_d = wr.wr_data[0];
                default: ;
            endcase
        end

        // A set on the commit cycle wins over a simultaneous clear
        irq_d = irq_q;
        if (commit)       irq_d = 1'b1;
        else if (irq_clr) irq_d = 1'b0;

        // One extra bit on every coordinate so X+16 past the right edge clips instead of wrapping
        hx    = {1'b0, hpos};
        vy    = {1'b0, vpos};
        x_lo  = {1'b0, x_act_q};
        y_lo  = {1'b0, y_act_q};
        x_hi  = x_lo + (COORD_W+1)'(16);
        y_hi  = y_lo + (COORD_W+1)'(16);
        hit_d = en_act_q && (hx >= x_lo) && (hx < x_hi) && (vy >= y_lo) && (vy < y_hi);
        // Low 4 bits of the offset only depend on the low 4 bits of each operand
        col_d = hpos[3:0] - x_act_q[3:0];
        row_d = vpos[3:0] - y_act_q[3:0];

        // Bit 15 is the leftmost pixel of a row
        row_bits = bitmap_q[row_q];
        if (!disp_q)                              rgb_d = 6'd0;
        else if (hit_q && row_bits[4'd15 - col_q]) rgb_d = fg_act_q;
        else                                      rgb_d = bg_act_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_pend_q <= '0; fg_pend_q <= '0; x_pend_q <= '0; y_pend_q <= '0; en_pend_q <= 1'b0;
            bg_act_q  <= '0; fg_act_q  <= '0; x_act_q  <= '0; y_act_q  <= '0; en_act_q  <= 1'b0;
            for (int i = 0; i < 16; i++) bitmap_q[i] <= '0;
            irq_q   <= 1'b0;
            frame_q <= '0;
            hit_q   <= 1'b0; col_q <= '0; row_q <= '0;
            disp_q  <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0;
            rgb_q   <= '0;   hs2_q <= 1'b0; vs2_q <= 1'b0;
        end else begin
            bg_pend_q <= bg_pend_d;
            fg_pend_q <= fg_pend_d;
            x_pend_q  <= x_pend_d;
            y_pend_q  <= y_pend_d;
            en_pend_q <= en_pend_d;
            // Active copies take the pre-write pending values, so a same-cycle write waits a frame
            if (commit) begin
                bg_act_q <= bg_pend_q;
                fg_act_q <= fg_pend_q;
                x_act_q  <= x_pend_q;
                y_act_q  <= y_pend_q;
                en_act_q <= en_pend_q;
                frame_q  <= frame_q + 16'd1;
            end
            // Bitmap is unshadowed; a same-cycle read in stage 2 still sees the old row
            if (wr.wr_en && (wr.wr_addr == 3'd4))
                bitmap_q[wr.wr_data[19:16]] <= wr.wr_data[15:0];
            irq_q  <= irq_d;
            hit_q  <= hit_d;  col_q <= col_d;    row_q <= row_d;
            disp_q <= display_on_in; hs1_q <= hsync_in; vs1_q <= vsync_in;
            rgb_q  <= rgb_d;  hs2_q <= hs1_q;    vs2_q <= vs1_q;
        end
    end

    assign rgb_out     = rgb_q;
    assign hsync_out   = hs2_q;
    assign vsync_out   = vs2_q;
    assign irq         = irq_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_video_sprite_pixel_gen.sv
module tb_video_sprite_pixel_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hpos, vpos;
    logic        hsync_in, vsync_in, display_on_in;
    logic [5:0]  rgb_out;
    logic        hsync_out, vsync_out, irq;
    logic [15:0] frame_count;
    int          total = 0;
    int          bad   = 0;

    video_sprite_pixel_gen_if wr_bus ();

    video_sprite_pixel_gen #(.COORD_W(10), .V_ACTIVE(480)) dut (
        .clk           (clk),
        .rst           (rst),
        .hpos          (hpos),
        .vpos          (vpos),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .display_on_in (display_on_in),
        .wr            (wr_bus.slave),
        .rgb_out       (rgb_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .irq           (irq),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One register write; the strobe is high for exactly one rising edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = a;
        wr_bus.wr_data = d;
        @(negedge clk);
        wr_bus.wr_en   = 1'b0;
    endtask

    // Present (hpos=0, vpos=480) for one edge, then move off it
    task automatic commit_frame();
        @(negedge clk);
        hpos = 10'd0; vpos = 10'd480;
        @(negedge clk);
        hpos = 10'd1; vpos = 10'd481;
    endtask

    // Drive one pixel coordinate and check the colour two edges later
    task automatic pix(input string tag, input int h, input int v, input logic disp, input logic [5:0] exp_c);
        @(negedge clk);
        hpos = 10'(h); vpos = 10'(v); display_on_in = disp;
        @(negedge clk);
        @(negedge clk);
        chk(tag, rgb_out, exp_c);
    endtask

    logic [7:0] hpat, vpat;

    initial begin
        rst = 1'b1;
        hpos = 10'd5; vpos = 10'd10;
        hsync_in = 1'b1; vsync_in = 1'b1; display_on_in = 1'b1;
        wr_bus.wr_en = 1'b0; wr_bus.wr_addr = 3'd0; wr_bus.wr_data = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rgb",   rgb_out, 6'd0);
        chk("rst_hs",    hsync_out, 1'b0);
        chk("rst_vs",    vsync_out, 1'b0);
        chk("rst_irq",   irq, 1'b0);
        chk("rst_frame", frame_count, 16'd0);
        rst = 1'b0;

        // Background only, sprite disabled
        wr(3'd0, 32'h30);
        pix("bg_before_commit", 10, 10, 1'b1, 6'h00);
        commit_frame();
        chk("frame_1", frame_count, 16'd1);
        chk("irq_set", irq, 1'b1);
        pix("bg_visible", 10, 10, 1'b1, 6'h30);
        pix("bg_blank",   10, 10, 1'b0, 6'h00);

        // Syncs delayed by exactly two cycles
        hpat = 8'b1011_0010;
        vpat = 8'b0110_1001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("hsync_dly", hsync_out, hpat[i-2]);
                chk("vsync_dly", vsync_out, vpat[i-2]);
            end
            hsync_in = hpat[i];
            vsync_in = vpat[i];
        end

        // irq clear, then clear on the commit cycle loses to set
        wr(3'd5, 32'h2);
        chk("irq_clr", irq, 1'b0);
        @(negedge clk);
        hpos = 10'd0; vpos = 10'd480;
        wr_bus.wr_en = 1'b1; wr_bus.wr_addr = 3'd5; wr_bus.wr_data = 32'h2;
        @(negedge clk);
        wr_bus.wr_en = 1'b0; hpos = 10'd1; vpos = 10'd481;
        chk("irq_set_wins", irq, 1'b1);
        chk("frame_2", frame_count, 16'd2);

        // Sprite at (100,50), rows 0x8001
        wr(3'd1, 32'h0C);
        wr(3'd0, 32'h03);
        wr(3'd2, 32'd100);
        wr(3'd3, 32'd50);
        for (int r = 0; r < 16; r++) wr(3'd4, (32'(r) << 16) | 32'h8001);
        wr(3'd5, 32'h1);
        pix("pending_not_live", 100, 50, 1'b1, 6'h30);
        commit_frame();
        pix("spr_x100", 100, 50, 1'b1, 6'h0C);
        pix("spr_x101", 101, 50, 1'b1, 6'h03);
        pix("spr_x115", 115, 50, 1'b1, 6'h0C);
        pix("spr_x116", 116, 50, 1'b1, 6'h03);
        pix("spr_x99",   99, 50, 1'b1, 6'h03);
        pix("spr_y65",  100, 65, 1'b1, 6'h0C);
        pix("spr_y66",  100, 66, 1'b1, 6'h03);
        pix("spr_y49",  100, 49, 1'b1, 6'h03);

        // Mid-frame X change is held until the next commit
        wr(3'd2, 32'd200);
        pix("old_x_kept", 100, 50, 1'b1, 6'h0C);
        pix("new_x_wait", 200, 50, 1'b1, 6'h03);
        commit_frame();
        chk("frame_4", frame_count, 16'd4);
        pix("new_x_live", 200, 50, 1'b1, 6'h0C);
        pix("old_x_gone", 100, 50, 1'b1, 6'h03);

        // Right-edge clipping at X=1020, no wrap into column 0..11
        wr(3'd2, 32'd1020);
        wr(3'd4, 32'h0000_FFFF);
        commit_frame();
        chk("frame_5", frame_count, 16'd5);
        pix("clip_1020", 1020, 50, 1'b1, 6'h0C);
        pix("clip_1023", 1023, 50, 1'b1, 6'h0C);
        pix("nowrap_0",     0, 50, 1'b1, 6'h03);
        pix("nowrap_3",     3, 50, 1'b1, 6'h03);
        pix("nowrap_11",   11, 50, 1'b1, 6'h03);

        // Row index 0x12 selects row 2; bitmap writes are live without a commit
        pix("row2_before", 1020, 52, 1'b1, 6'h0C);
        wr(3'd4, 32'h0012_0000);
        pix("row2_cleared", 1020, 52, 1'b1, 6'h03);

        // Reset for one cycle mid-line
        @(negedge clk);
        hpos = 10'd1020; vpos = 10'd50; display_on_in = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rgb",   rgb_out, 6'd0);
        chk("midrst_irq",   irq, 1'b0);
        chk("midrst_frame", frame_count, 16'd0);
        pix("midrst_bg0", 1020, 50, 1'b1, 6'h00);
        wr(3'd6, 32'h3F);
        wr(3'd7, 32'h3F);
        commit_frame();
        chk("midrst_frame1", frame_count, 16'd1);
        pix("pending_cleared", 1020, 50, 1'b1, 6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_sprite_pixel_gen.md
Name: video_sprite_pixel_gen

Overview:
- Downstream stage of the VGA timing generator. Consumes hpos/vpos/hsync/vsync/display_on and produces 6-bit RRGGBB pixel colour with timing-aligned syncs.
- Draws a programmable background colour and one 16x16 monochrome sprite.
- Sprite position, colours and enable are written by the TinyQV peripheral wrapper and shadow-committed once per frame at the start of vertical blanking. The same event raises a vblank interrupt and advances a frame counter.

Parameters:
- COORD_W, 10, width of hpos/vpos and sprite coordinates.
- V_ACTIVE, 480, first non-visible line; frame commit occurs at (hpos==0, vpos==V_ACTIVE).

Ports:
- clk  in  1  system clock (64 MHz), single clock domain.
- rst  in  1  synchronous, active-high reset.
- hpos  in  COORD_W  current pixel column from timing generator.
- vpos  in  COORD_W  current line from timing generator.
- hsync_in  in  1  horizontal sync from timing generator.
- vsync_in  in  1  vertical sync from timing generator.
- display_on_in  in  1  visible-area flag.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_addr  in  3  register select.
- wr_data  in  32  write data.
- rgb_out  out  6  pixel colour {R1,R0,G1,G0,B1,B0}.
- hsync_out  out  1  hsync delayed to align with rgb_out.
- vsync_out  out  1  vsync delayed to align with rgb_out.
- irq  out  1  vblank interrupt, level, sticky.
- frame_count  out  16  frames committed since reset.

Behaviour:
- Reset: rgb_out, hsync_out, vsync_out, irq, frame_count are 0. All pending and active registers are 0, bitmap is all 0, pipeline valid/sync stages are 0.
- Registers (written on wr_en; writes go to the pending copy unless noted):
  - 0 BG colour [5:0]
  - 1 FG colour [5:0]
  - 2 sprite X [9:0]
  - 3 sprite Y [9:0]
  - 4 bitmap row, written directly with no shadow: row index = wr_data[19:16] (bits 19:16 treated mod 16), row bits = wr_data[15:0]
  - 5 control: bit0 = sprite enable (pending); bit1 = irq clear (write-1 strobe, not stored)
  - addresses 6 and 7 are ignored.
- Commit: on the cycle hpos==0 and vpos==V_ACTIVE, copy all pending registers into the active copies, set irq, and increment frame_count (0xFFFF wraps to 0).
  - A write in the same cycle as commit lands in pending and is not committed until the next frame.
- irq priority: a set and a clear in the same cycle leave irq = 1.
- Pipeline, 2 cycles:
  - Stage 1 registers: hit = active_en && hpos >= X && hpos < X+16 && vpos >= Y && vpos < Y+16. All comparisons use COORD_W+1 bits, so there is no wrap; a sprite at X=1020 clips at the right edge. Stage 1 also registers col = hpos-X [3:0], row = vpos-Y [3:0], and delayed display_on/hsync/vsync.
  - Stage 2 registers: rgb_out = !disp_d ? 0 : (hit_d && bitmap[row][15-col]) ? FG : BG. Bit 15 of a row is the leftmost pixel. hsync_out/vsync_out are the second delay stage.
- Bitmap write and read of the same row in one cycle: stage 2 sees the old row value.
- Sync polarity is passed through unchanged; rgb_out is forced to 0 whenever delayed display_on = 0.
- Reset asserted mid-frame clears everything within one cycle. After release, outputs stay 0 until real data has propagated through both stages.

Test Plan:
- Reset then free-running timing with BG=0x30, sprite disabled -> after commit, rgb_out=0x30 at every visible pixel, 0 in blanking; hsync_out/vsync_out equal the inputs delayed by exactly 2 cycles.
- X=100, Y=50, FG=0x0C, BG=0x03, all rows=0x8001, enable=1, then commit -> at line 50: pixel 100 = 0x0C, pixel 101 = 0x03, pixel 115 = 0x0C, pixel 116 = 0x03; line 66 is all 0x03.
- Write X=200 mid-frame (vpos=10) -> the current frame still draws at the old X; the frame after commit draws at 200; frame_count increments by exactly 1 per commit.
- irq set at commit; write addr5 data 0x2 -> irq=0 next cycle; clear issued on the commit cycle -> irq stays 1.
- X=1020, row bits=0xFFFF -> FG only at pixels 1020..1023 (if the timing generator emits them), with no wrap-around hit at pixels 0..11.
- Assert rst for 1 cycle mid-line -> rgb_out, irq and frame_count are 0 the next cycle; pending and active registers are cleared, so BG=0 until reprogrammed.
